// File: rtl/sequential_divider_pkg.sv
// sequential_divider_pkg
// Shared definitions for the iterative restoring divider.
//   - DEFAULT_WIDTH_N / DEFAULT_WIDTH_D : default dividend and divisor widths
//   - state_t                           : controller state encoding
//   - counter_width()                   : sizing helper for the step counter
package sequential_divider_pkg;

    localparam int DEFAULT_WIDTH_N = 5;
    localparam int DEFAULT_WIDTH_D = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must hold steps-1; a one-step divider still needs one bit.
    function automatic int counter_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// sequential_divider_if
// Start/done handshake plus operand and result bus of the sequential divider.
// Parameters: WIDTH_N (dividend/quotient width), WIDTH_D (divisor/remainder width).
// Signals:
//   start      controller -> divider  request, sampled only while idle
//   dividend   controller -> divider  WIDTH_N operand
//   divisor    controller -> divider  WIDTH_D operand
//   busy       divider -> controller  high while iterating
//   done       divider -> controller  one-cycle completion pulse
//   quotient   divider -> controller  WIDTH_N result
//   remainder  divider -> controller  WIDTH_D result
//   divByZero  divider -> controller  zero-divisor flag, qualified by done
// Modports: master (controller side), slave (divider side).
interface sequential_divider_if
    import sequential_divider_pkg::*;
#(
    parameter int WIDTH_N = DEFAULT_WIDTH_N,
    parameter int WIDTH_D = DEFAULT_WIDTH_D
);

    logic               start;
    logic [WIDTH_N-1:0] dividend;
    logic [WIDTH_D-1:0] divisor;
    logic               busy;
    logic               done;
    logic [WIDTH_N-1:0] quotient;
    logic [WIDTH_D-1:0] remainder;
    logic               divByZero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  divByZero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output divByZero
    );

endinterface

// File: rtl/sequential_divider_step.sv
// divider_step
// One combinational step of a restoring divider: shift the next dividend bit
// into the partial remainder, compare against the divisor and subtract when it
// fits. Kept separate so an unrolled array divider can chain these cells.
// Ports:
//   rem_in   WIDTH_D+1  partial remainder before this step
//   bit_in   1          next dividend bit (MSB first)
//   divisor  WIDTH_D    divisor
//   rem_out  WIDTH_D+1  partial remainder after this step
//   q_bit    1          quotient bit produced by this step
module divider_step
    import sequential_divider_pkg::*;
#(
    parameter int WIDTH_D = DEFAULT_WIDTH_D
) (
    input  logic [WIDTH_D:0]   rem_in,
    input  logic               bit_in,
    input  logic [WIDTH_D-1:0] divisor,
    output logic [WIDTH_D:0]   rem_out,
    output logic               q_bit
);

    logic [WIDTH_D:0] shifted;
    logic [WIDTH_D:0] divisor_ext;

    // The partial remainder stays below the divisor between steps, so its MSB
    // is shifted out and never needed here.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_in[WIDTH_D];

    assign shifted     = {rem_in[WIDTH_D-1:0], bit_in};
    // Compare at WIDTH_D+1 bits: the shifted value can exceed the divisor range.
    assign divisor_ext = {1'b0, divisor};

    always_comb begin
        q_bit   = 1'b0;
        rem_out = shifted;
        if (shifted >= divisor_ext) begin
            q_bit   = 1'b1;
            rem_out = shifted - divisor_ext;
        end
    end

endmodule

// File: rtl/sequential_divider.sv
// sequential_divider
// Iterative unsigned restoring divider, one quotient bit per clock.
// quotient = dividend / divisor, remainder = dividend % divisor.
// Optional feature macro: SEQUENTIAL_DIVIDER_DIV_BY_ZERO_EN
//   defined   : zero divisor detected at acceptance, skips RUN, sets divByZero
//   undefined : zero divisor runs normally, divByZero tied low
// Parameters: WIDTH_N (dividend/quotient width), WIDTH_D (divisor/remainder width).
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset, returns to IDLE and clears registers
//   bus    sequential_divider_if.slave handshake, operand and result bus
module sequential_divider
    import sequential_divider_pkg::*;
#(
    parameter int WIDTH_N = DEFAULT_WIDTH_N,
    parameter int WIDTH_D = DEFAULT_WIDTH_D
) (
    input  logic           clock,
    input  logic           reset,
    sequential_divider_if.slave bus
);

    localparam int CNT_W = counter_width(WIDTH_N);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH_N - 1);

    state_t             state;
    logic [WIDTH_D:0]   part_rem;
    logic [WIDTH_N-1:0] shift_q;
    logic [WIDTH_D-1:0] divisor_reg;
    logic [CNT_W-1:0]   count;

    logic               busy_r;
    logic               done_r;
    logic [WIDTH_N-1:0] quotient_r;
    logic [WIDTH_D-1:0] remainder_r;
`ifdef SEQUENTIAL_DIVIDER_DIV_BY_ZERO_EN
    logic               div_by_zero_r;
`endif

    logic [WIDTH_D:0]   next_rem;
    logic               q_bit;
    logic [WIDTH_N-1:0] next_q;

    // One step of the divide, fed by the dividend MSB still sitting in Q.
    divider_step #(
        .WIDTH_D (WIDTH_D)
    ) u_step (
        .rem_in  (part_rem),
        .bit_in  (shift_q[WIDTH_N-1]),
        .divisor (divisor_reg),
        .rem_out (next_rem),
        .q_bit   (q_bit)
    );

    // Q shifts left as dividend bits are consumed and quotient bits fill in
    // from the bottom, so one register serves as both.
    assign next_q = WIDTH_N'({shift_q, q_bit});

    // Controller: counts WIDTH_N steps, then publishes the result for one
    // DONE cycle. Requests arriving outside IDLE are simply dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            part_rem      <= '0;
            shift_q       <= '0;
            divisor_reg   <= '0;
            count         <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            quotient_r    <= '0;
            remainder_r   <= '0;
`ifdef SEQUENTIAL_DIVIDER_DIV_BY_ZERO_EN
            div_by_zero_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        divisor_reg <= bus.divisor;
                        shift_q     <= bus.dividend;
                        part_rem    <= '0;
                        count       <= LAST_STEP;
                        busy_r      <= 1'b1;
                        state       <= RUN;
`ifdef SEQUENTIAL_DIVIDER_DIV_BY_ZERO_EN
                        // A zero divisor overrides the launch above and
                        // reports immediately without iterating.
                        if (bus.divisor == '0) begin
                            busy_r        <= 1'b0;
                            done_r        <= 1'b1;
                            quotient_r    <= '1;
                            remainder_r   <= '0;
                            div_by_zero_r <= 1'b1;
                            state         <= DONE;
                        end
`endif
                    end
                end

                RUN: begin
                    part_rem <= next_rem;
                    shift_q  <= next_q;
                    count    <= count - 1'b1;
                    if (count == '0) begin
                        quotient_r    <= next_q;
                        remainder_r   <= next_rem[WIDTH_D-1:0];
`ifdef SEQUENTIAL_DIVIDER_DIV_BY_ZERO_EN
                        div_by_zero_r <= 1'b0;
`endif
                        busy_r        <= 1'b0;
                        done_r        <= 1'b1;
                        state         <= DONE;
                    end
                end

                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
`ifdef SEQUENTIAL_DIVIDER_DIV_BY_ZERO_EN
    assign bus.divByZero = div_by_zero_r;
`else
    assign bus.divByZero = 1'b0;
`endif

endmodule
